// File: rtl/hc595_shift_driver.sv
// Serialises a DATA_W-bit word MSB first into a 74HC595 chain, then pulses the storage latch.
// hc595_clk runs at sys_clk / (2*CLK_DIV); every output is a register.

module hc595_shift_driver #(
  parameter int DATA_W  = 16,
  parameter int CLK_DIV = 4
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              din_valid,
  input  logic [DATA_W-1:0] din_data,
  output logic              din_ready,
  output logic              hc595_data,
  output logic              hc595_clk,
  output logic              hc595_cs,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(DATA_W - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT_LO,
    SHIFT_HI,
    LATCH
  } state_t;

  state_t            state, state_d;
  logic [DATA_W-1:0] shift_reg, shift_d;
  logic [CNT_W-1:0]  bit_cnt, bit_cnt_d;
  logic [DIV_W-1:0]  div_cnt, div_cnt_d;
  logic              data_d;
  logic              div_end;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state      <= IDLE;
      shift_reg  <= '0;
      bit_cnt    <= '0;
      div_cnt    <= '0;
      din_ready  <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      hc595_data <= 1'b0;
      hc595_clk  <= 1'b0;
      hc595_cs   <= 1'b0;
    end else begin
      state      <= state_d;
      shift_reg  <= shift_d;
      bit_cnt    <= bit_cnt_d;
      div_cnt    <= div_cnt_d;
      din_ready  <= (state_d == IDLE);
      busy       <= (state_d != IDLE);
      done       <= (state == LATCH) && (state_d == IDLE);
      hc595_data <= data_d;
      hc595_clk  <= (state_d == SHIFT_HI);
      hc595_cs   <= (state_d == LATCH);
    end
  end

  // Each timed state holds CLK_DIV cycles; serial data only moves when entering SHIFT_LO.
  always_comb begin
    state_d   = state;
    shift_d   = shift_reg;
    bit_cnt_d = bit_cnt;
    div_cnt_d = div_cnt;
    data_d    = hc595_data;
    div_end   = (div_cnt == DIV_LAST);

    case (state)
      IDLE: begin
        if (din_valid && din_ready) begin
          state_d   = SHIFT_LO;
          shift_d   = din_data;
          bit_cnt_d = BIT_LAST;
          div_cnt_d = '0;
          data_d    = din_data[DATA_W-1];
        end
      end
      SHIFT_LO: begin
        if (div_end) begin
          state_d   = SHIFT_HI;
          div_cnt_d = '0;
        end else begin
          div_cnt_d = div_cnt + 1'b1;
        end
      end
      SHIFT_HI: begin
        if (div_end) begin
          div_cnt_d = '0;
          if (bit_cnt == '0) begin
            state_d = LATCH;
          end else begin
            state_d   = SHIFT_LO;
            shift_d   = shift_reg << 1;
            bit_cnt_d = bit_cnt - 1'b1;
            data_d    = shift_reg[DATA_W-2];
          end
        end else begin
          div_cnt_d = div_cnt + 1'b1;
        end
      end
      LATCH: begin
        if (div_end) begin
          state_d   = IDLE;
          div_cnt_d = '0;
        end else begin
          div_cnt_d = div_cnt + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_hc595_shift_driver.sv
// Bench for hc595_shift_driver: one instance at defaults, one with CLK_DIV=1.
// A negedge monitor reconstructs what a 74HC595 chain would see and the checks compare it to the sent words.

module tb_hc595_shift_driver;

  localparam int DW  = 16;
  localparam int CD0 = 4;
  localparam int CD1 = 1;

  logic          sys_clk = 1'b0;
  logic          sys_rst    [2];
  logic          din_valid  [2];
  logic [DW-1:0] din_data   [2];
  logic          din_ready  [2];
  logic          hc595_data [2];
  logic          hc595_clk  [2];
  logic          hc595_cs   [2];
  logic          busy       [2];
  logic          done       [2];

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  int          rise_cnt   [2];
  int          last_rise  [2];
  int          period_err [2];
  int          cs_cycles  [2];
  int          cs_pulses  [2];
  int          done_cnt   [2];
  int          done_cyc   [2];
  logic [31:0] bit_word   [2] = '{32'd0, 32'd0};
  bit          rise_valid [2];
  bit          clk_prev   [2];
  bit          cs_prev    [2];

  hc595_shift_driver #(.DATA_W(DW), .CLK_DIV(CD0)) dut0 (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst[0]),
    .din_valid (din_valid[0]),
    .din_data  (din_data[0]),
    .din_ready (din_ready[0]),
    .hc595_data(hc595_data[0]),
    .hc595_clk (hc595_clk[0]),
    .hc595_cs  (hc595_cs[0]),
    .busy      (busy[0]),
    .done      (done[0])
  );

  hc595_shift_driver #(.DATA_W(DW), .CLK_DIV(CD1)) dut1 (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst[1]),
    .din_valid (din_valid[1]),
    .din_data  (din_data[1]),
    .din_ready (din_ready[1]),
    .hc595_data(hc595_data[1]),
    .hc595_clk (hc595_clk[1]),
    .hc595_cs  (hc595_cs[1]),
    .busy      (busy[1]),
    .done      (done[1])
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc <= cyc + 1;

  function automatic int div_of(input int i);
    return (i == 0) ? CD0 : CD1;
  endfunction

  // Model of the receiving shift register chain: a bit is taken on every hc595_clk rise.
  always @(negedge sys_clk) begin
    for (int i = 0; i < 2; i++) begin
      if (hc595_clk[i] && !clk_prev[i]) begin
        if (rise_valid[i] && (cyc - last_rise[i]) != 2 * div_of(i)) period_err[i]++;
        rise_valid[i] = 1'b1;
        last_rise[i]  = cyc;
        rise_cnt[i]++;
        bit_word[i] = {bit_word[i][30:0], hc595_data[i]};
      end
      if (hc595_cs[i] || sys_rst[i]) rise_valid[i] = 1'b0;
      if (hc595_cs[i]) cs_cycles[i]++;
      if (hc595_cs[i] && !cs_prev[i]) cs_pulses[i]++;
      if (done[i]) begin
        done_cnt[i]++;
        done_cyc[i] = cyc;
      end
      clk_prev[i] = hc595_clk[i];
      cs_prev[i]  = hc595_cs[i];
    end
  end

  task automatic tick();
    @(negedge sys_clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [5:0] out_vec(input int i);
    return {din_ready[i], busy[i], done[i], hc595_data[i], hc595_clk[i], hc595_cs[i]};
  endfunction

  // Presents a word while the driver is ready; acc_cyc is the cycle number of the accepted cycle.
  task automatic applyStimulus(input int i, input logic [DW-1:0] word, input bit hold_valid,
                               output int acc_cyc);
    int n = 0;
    while (!din_ready[i] && n < 1000) begin
      tick();
      n++;
    end
    checkOutput("ready_before_send", 32'(din_ready[i]), 32'd1);
    din_valid[i] = 1'b1;
    din_data[i]  = word;
    acc_cyc      = cyc + 1;
    tick();
    if (!hold_valid) din_valid[i] = 1'b0;
    checkOutput("busy_after_accept", 32'({busy[i], din_ready[i]}), 32'b10);
  endtask

  task automatic run_word(input int i, input logic [DW-1:0] word, input bit toggle);
    int acc;
    int n  = 0;
    int cd = div_of(i);
    int r0 = rise_cnt[i];
    int c0 = cs_cycles[i];
    int p0 = cs_pulses[i];
    int d0 = done_cnt[i];
    int e0 = period_err[i];
    applyStimulus(i, word, 1'b0, acc);
    while (done_cnt[i] == d0 && n < 2000) begin
      if (toggle && n < 100) begin
        din_valid[i] = 1'($urandom_range(0, 1));
        din_data[i]  = DW'($urandom);
      end else begin
        din_valid[i] = 1'b0;
      end
      tick();
      n++;
    end
    din_valid[i] = 1'b0;
    checkOutput("done_seen", 32'(done_cnt[i] - d0), 32'd1);
    checkOutput("latency", 32'(done_cyc[i] - acc + 1), 32'(2 * DW * cd + cd + 1));
    checkOutput("done_cycle_flags", 32'({done[i], din_ready[i], busy[i]}), 32'b110);
    checkOutput("shifted_word", 32'(bit_word[i][DW-1:0]), 32'(word));
    checkOutput("clk_rises", 32'(rise_cnt[i] - r0), 32'(DW));
    checkOutput("cs_high_cycles", 32'(cs_cycles[i] - c0), 32'(cd));
    checkOutput("cs_pulses", 32'(cs_pulses[i] - p0), 32'd1);
    checkOutput("clk_period", 32'(period_err[i] - e0), 32'd0);
    tick();
    checkOutput("done_one_cycle", 32'(done[i]), 32'd0);
  endtask

  initial begin
    int acc, acc2, n, d0, p0, r0;
    logic [DW-1:0] w;

    for (int i = 0; i < 2; i++) begin
      sys_rst[i]   = 1'b1;
      din_valid[i] = 1'b0;
      din_data[i]  = '0;
    end
    repeat (3) tick();
    checkOutput("reset_hold_dut0", 32'(out_vec(0)), 32'b100000);
    checkOutput("reset_hold_dut1", 32'(out_vec(1)), 32'b100000);
    sys_rst[0] = 1'b0;
    sys_rst[1] = 1'b0;
    tick();
    checkOutput("after_release_dut0", 32'(out_vec(0)), 32'b100000);
    checkOutput("after_release_dut1", 32'(out_vec(1)), 32'b100000);

    run_word(0, 16'hA5C3, 1'b0);
    run_word(1, 16'h8001, 1'b0);

    // Back-to-back: valid stays high, second word must be taken in the first word's done cycle.
    d0 = done_cnt[0];
    p0 = cs_pulses[0];
    applyStimulus(0, 16'h1234, 1'b1, acc);
    din_data[0] = 16'hFFFF;
    n = 0;
    while (done_cnt[0] == d0 && n < 2000) begin
      tick();
      n++;
    end
    checkOutput("b2b_first_latency", 32'(done_cyc[0] - acc + 1), 32'(2 * DW * CD0 + CD0 + 1));
    checkOutput("b2b_first_word", 32'(bit_word[0][DW-1:0]), 32'h1234);
    checkOutput("b2b_ready_in_done", 32'(din_ready[0]), 32'd1);
    acc2 = cyc + 1;
    tick();
    din_valid[0] = 1'b0;
    checkOutput("b2b_second_accepted", 32'(busy[0]), 32'd1);
    n = 0;
    while (done_cnt[0] < d0 + 2 && n < 2000) begin
      tick();
      n++;
    end
    checkOutput("b2b_both_words", bit_word[0], 32'h1234_FFFF);
    checkOutput("b2b_second_latency", 32'(done_cyc[0] - acc2 + 1), 32'(2 * DW * CD0 + CD0 + 1));
    checkOutput("b2b_cs_pulses", 32'(cs_pulses[0] - p0), 32'd2);
    tick();

    run_word(0, DW'($urandom), 1'b1);

    // Reset in the 8th high phase of hc595_clk abandons the transfer.
    r0 = rise_cnt[0];
    p0 = cs_pulses[0];
    d0 = done_cnt[0];
    w  = DW'($urandom);
    applyStimulus(0, w, 1'b0, acc);
    n = 0;
    while (rise_cnt[0] - r0 < 8 && n < 2000) begin
      tick();
      n++;
    end
    checkOutput("reached_8th_rise", 32'(rise_cnt[0] - r0), 32'd8);
    checkOutput("in_shift_hi", 32'(hc595_clk[0]), 32'd1);
    sys_rst[0] = 1'b1;
    #1;
    checkOutput("mid_reset_outputs", 32'(out_vec(0)), 32'b100000);
    repeat (3) tick();
    sys_rst[0] = 1'b0;
    repeat (200) tick();
    checkOutput("no_cs_after_abort", 32'(cs_pulses[0] - p0), 32'd0);
    checkOutput("no_done_after_abort", 32'(done_cnt[0] - d0), 32'd0);

    run_word(0, DW'($urandom), 1'b0);
    run_word(1, DW'($urandom), 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
